// File: rtl/satadd_arb.sv
// Two-requester round-robin front end for a shared 12-bit saturating adder,
// with a one-entry result register drained over a valid/ready handshake.

module satadd_core #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_mode,
  output logic [WIDTH-1:0] o_y,
  output logic             o_sat
);

  localparam logic [WIDTH-1:0] MAX_U = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MAX_S = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_S = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] w_sum;
  logic           w_carry;
  logic           w_sovf;

  assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
  assign w_carry = w_sum[WIDTH];
  // Signed overflow: operands agree in sign but the truncated sum does not.
  assign w_sovf  = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);

  always_comb begin
    o_y   = w_sum[WIDTH-1:0];
    o_sat = 1'b0;
    case (i_mode)
      2'b00: begin
        if (w_carry) begin
          o_y   = MAX_U;
          o_sat = 1'b1;
        end
      end
      2'b01: begin
        if (w_sovf) begin
          o_y   = i_a[WIDTH-1] ? MIN_S : MAX_S;
          o_sat = 1'b1;
        end
      end
      default: begin
        o_y   = w_sum[WIDTH-1:0];
        o_sat = 1'b0;
      end
    endcase
  end

endmodule

module satadd_arb #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_mode,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_y,
  output logic             res_id,
  output logic             res_sat
);

  logic             r_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_id;
  logic             r_sat;
  logic             r_last_id;

  logic             w_space;
  logic             w_grant;
  logic             w_accept;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [1:0]       w_mode;
  logic [WIDTH-1:0] w_y;
  logic             w_sat;

  assign w_space = !r_valid || res_ready;

  // Contention goes to whoever did not win last; a lone requester always wins.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = !r_last_id;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  assign req0_ready = w_space && !w_grant;
  assign req1_ready = w_space &&  w_grant;
  assign w_accept   = w_grant ? (req1_valid && req1_ready) : (req0_valid && req0_ready);

  assign w_a    = w_grant ? req1_a    : req0_a;
  assign w_b    = w_grant ? req1_b    : req0_b;
  assign w_mode = w_grant ? req1_mode : req0_mode;

  satadd_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_a    (w_a),
    .i_b    (w_b),
    .i_mode (w_mode),
    .o_y    (w_y),
    .o_sat  (w_sat)
  );

  // An accept overrides a same-cycle drain so the register refills without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_y       <= '0;
      r_id      <= 1'b0;
      r_sat     <= 1'b0;
      r_last_id <= 1'b1;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_y       <= w_y;
      r_id      <= w_grant;
      r_sat     <= w_sat;
      r_last_id <= w_grant;
    end else if (res_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign res_valid = r_valid;
  assign res_y     = r_y;
  assign res_id    = r_id;
  assign res_sat   = r_sat;

endmodule
